// File: rtl/mux_pipeline_if.sv
// rtl/mux_pipeline_if.sv - lane, select and tag bundle for mux_pipeline
interface mux_pipeline_if #(
  parameter int WIDTH       = 1,
  parameter int INPUT_COUNT = 2
);
  localparam int SELECT_SIZE = $clog2(INPUT_COUNT);

  logic [SELECT_SIZE-1:0]       sel;
  logic [WIDTH*INPUT_COUNT-1:0] in;
  logic                         in_valid;
  logic [WIDTH-1:0]             out;
  logic                         out_valid;
  logic [SELECT_SIZE-1:0]       out_sel;

  modport master (output sel, in, in_valid, input out, out_valid, out_sel);
  modport slave  (input sel, in, in_valid, output out, out_valid, out_sel);
endinterface

// File: rtl/mux_pipeline.sv
// rtl/mux_pipeline.sv - pipelined N:1 mux tree with fixed latency and valid/select tags
module mux_pipeline #(
  parameter int WIDTH       = 1,
  parameter int INPUT_COUNT = 2,
  parameter int LATENCY     = 0,
  parameter int PRINT       = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  mux_pipeline_if.slave bus
);
  localparam int SELECT_SIZE     = $clog2(INPUT_COUNT);
  localparam int SEL_WIDTH       = (LATENCY == 0) ? SELECT_SIZE
                                   : (SELECT_SIZE + LATENCY - 1) / LATENCY;
  localparam int MUX_SIZE        = 1 << SEL_WIDTH;
  localparam int STRUCTURE_DEPTH = (SELECT_SIZE + SEL_WIDTH - 1) / SEL_WIDTH;
  localparam int PAD             = (LATENCY > STRUCTURE_DEPTH) ? LATENCY - STRUCTURE_DEPTH : 0;
  localparam int SEL_PAD         = STRUCTURE_DEPTH * SEL_WIDTH;
  localparam int LW              = WIDTH * INPUT_COUNT;

  if (INPUT_COUNT < 2) begin : g_bad_count
    $error("mux_pipeline: INPUT_COUNT must be at least 2");
  end

  if (PRINT != 0) begin : g_print
    $info("mux_pipeline: SELECT_SIZE=%0d SEL_WIDTH=%0d MUX_SIZE=%0d STRUCTURE_DEPTH=%0d padding=%0d",
          SELECT_SIZE, SEL_WIDTH, MUX_SIZE, STRUCTURE_DEPTH, PAD);
  end

  // Number of live lanes entering tree level lvl; lanes beyond it are always zero.
  function automatic int lanes_at(int lvl);
    int c;
    c = INPUT_COUNT;
    for (int k = 0; k < STRUCTURE_DEPTH; k++)
      if (k < lvl) c = (c + MUX_SIZE - 1) / MUX_SIZE;
    return c;
  endfunction

  function automatic int digit(logic [SELECT_SIZE-1:0] s, int lvl);
    logic [SEL_PAD-1:0] e;
    e = '0;
    e[SELECT_SIZE-1:0] = s;
    return int'(e[lvl*SEL_WIDTH +: SEL_WIDTH]);
  endfunction

  // One tree level: output lane j picks member dg of group j; absent members read as zero.
  function automatic logic [LW-1:0] mux_level(logic [LW-1:0] d, int dg, int lvl);
    logic [LW-1:0] r;
    int n_in;
    int n_out;
    int idx;
    n_in  = lanes_at(lvl);
    n_out = lanes_at(lvl + 1);
    r     = '0;
    for (int j = 0; j < INPUT_COUNT; j++) begin
      idx = j * MUX_SIZE + dg;
      if (j < n_out && idx < n_in) r[j*WIDTH +: WIDTH] = d[idx*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  if (LATENCY == 0) begin : g_comb
    logic [LW-1:0] tree_d;
    logic          unused_ok;

    assign unused_ok = &{1'b0, clk, rst_n, ce};

    always_comb begin
      tree_d = bus.in;
      for (int i = 0; i < STRUCTURE_DEPTH; i++)
        tree_d = mux_level(tree_d, digit(bus.sel, i), i);
    end

    assign bus.out       = tree_d[WIDTH-1:0];
    assign bus.out_valid = bus.in_valid;
    assign bus.out_sel   = bus.sel;
  end else begin : g_pipe
    logic [LW-1:0]          mx   [STRUCTURE_DEPTH];
    logic [LW-1:0]          rk_d [STRUCTURE_DEPTH];
    logic [SELECT_SIZE-1:0] tg_s [LATENCY];
    logic                   tg_v [LATENCY];
    logic [WIDTH-1:0]       tree_out;
    logic                   unused_hi;

    // Tag rank i-1 is aligned with data rank i-1, so it carries level i's select digit.
    always_comb begin
      mx[0] = mux_level(bus.in, digit(bus.sel, 0), 0);
      for (int i = 1; i < STRUCTURE_DEPTH; i++)
        mx[i] = mux_level(rk_d[i-1], digit(tg_s[i-1], i), i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < STRUCTURE_DEPTH; i++) rk_d[i] <= '0;
        for (int i = 0; i < LATENCY; i++) begin
          tg_s[i] <= '0;
          tg_v[i] <= 1'b0;
        end
      end else if (ce) begin
        for (int i = 0; i < STRUCTURE_DEPTH; i++) rk_d[i] <= mx[i];
        tg_s[0] <= bus.sel;
        tg_v[0] <= bus.in_valid;
        for (int i = 1; i < LATENCY; i++) begin
          tg_s[i] <= tg_s[i-1];
          tg_v[i] <= tg_v[i-1];
        end
      end
    end

    assign tree_out      = rk_d[STRUCTURE_DEPTH-1][WIDTH-1:0];
    assign unused_hi     = ^rk_d[STRUCTURE_DEPTH-1][LW-1:WIDTH];
    assign bus.out_valid = tg_v[LATENCY-1];
    assign bus.out_sel   = tg_s[LATENCY-1];

    if (PAD == 0) begin : g_nopad
      assign bus.out = tree_out;
    end else begin : g_pad
      logic [WIDTH-1:0] pd [PAD];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PAD; i++) pd[i] <= '0;
        end else if (ce) begin
          pd[0] <= tree_out;
          for (int i = 1; i < PAD; i++) pd[i] <= pd[i-1];
        end
      end

      assign bus.out = pd[PAD-1];
    end
  end
endmodule

// File: tb/tb_mux_pipeline.sv
// tb/tb_mux_pipeline.sv - bench for mux_pipeline across several lane counts and latencies
module tb_mux_pipeline;
  localparam int NC   = 7;
  localparam int MAXN = 33;
  localparam int CN [NC] = '{8, 5, 8, 4, 7, 16, 33};
  localparam int CL [NC] = '{3, 2, 4, 5, 0, 6, 2};

  typedef struct packed {
    logic       v;
    logic [5:0] s;
    logic [7:0] d;
  } exp_t;

  typedef struct packed {
    logic [5:0] sel0;
    logic [7:0] exp0;
    logic [5:0] sel1;
    logic [7:0] exp1;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              ce;
  logic              dvalid;
  logic [MAXN*8-1:0] lanes;
  logic [5:0]        dsel [NC];
  logic [7:0]        o_d  [NC];
  logic [5:0]        o_s  [NC];
  logic              o_v  [NC];
  exp_t              sbq  [NC][$];
  int                total = 0;
  int                bad   = 0;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int N = CN[g];
    localparam int S = $clog2(N);

    mux_pipeline_if #(.WIDTH(8), .INPUT_COUNT(N)) bus ();

    mux_pipeline #(.WIDTH(8), .INPUT_COUNT(N), .LATENCY(CL[g]), .PRINT(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .bus   (bus.slave)
    );

    assign bus.sel      = dsel[g][S-1:0];
    assign bus.in       = lanes[N*8-1:0];
    assign bus.in_valid = dvalid;
    assign o_d[g]       = bus.out;
    assign o_s[g]       = 6'(bus.out_sel);
    assign o_v[g]       = bus.out_valid;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sbits(int i);
    return $clog2(CN[i]);
  endfunction

  function automatic exp_t model(int i);
    exp_t e;
    int   s;
    s   = int'(dsel[i]);
    e.v = dvalid;
    e.s = dsel[i];
    e.d = (s < CN[i]) ? lanes[s*8 +: 8] : 8'h00;
    return e;
  endfunction

  function automatic exp_t observe(int i);
    exp_t a;
    a.v = o_v[i];
    a.s = o_s[i];
    a.d = o_d[i];
    return a;
  endfunction

  task automatic chk(string name, int i, exp_t act, exp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got v=%0b sel=%0d out=%02h, want v=%0b sel=%0d out=%02h",
               name, i, act.v, act.s, act.d, exp.v, exp.s, exp.d);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < NC; i++) begin
      sbq[i].delete();
      for (int k = 0; k < CL[i]; k++) sbq[i].push_back('0);
    end
  endtask

  // Push the driven sample on each enabled edge, retire the oldest, compare the front.
  task automatic tick();
    @(posedge clk);
    if (rst_n && ce)
      for (int i = 0; i < NC; i++)
        if (CL[i] > 0) begin
          sbq[i].push_back(model(i));
          void'(sbq[i].pop_front());
        end
    #1;
    for (int i = 0; i < NC; i++)
      chk("scoreboard", i, observe(i), (CL[i] > 0) ? sbq[i][0] : model(i));
    @(negedge clk);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < MAXN; k++) lanes[k*8 +: 8] = 8'(16 + k);
  endtask

  task automatic drive_random();
    for (int k = 0; k < MAXN; k++) lanes[k*8 +: 8] = 8'($urandom);
    for (int i = 0; i < NC; i++) dsel[i] = 6'($urandom & ((1 << sbits(i)) - 1));
    dvalid = 1'($urandom);
  endtask

  initial begin
    vec_t tbl [8];
    exp_t got_q [$];
    exp_t z;

    tbl[0] = '{6'd0, 8'h10, 6'd6, 8'h00};
    tbl[1] = '{6'd1, 8'h11, 6'd0, 8'h10};
    tbl[2] = '{6'd2, 8'h12, 6'd4, 8'h14};
    tbl[3] = '{6'd3, 8'h13, 6'd5, 8'h00};
    tbl[4] = '{6'd4, 8'h14, 6'd7, 8'h00};
    tbl[5] = '{6'd5, 8'h15, 6'd3, 8'h13};
    tbl[6] = '{6'd6, 8'h16, 6'd1, 8'h11};
    tbl[7] = '{6'd7, 8'h17, 6'd2, 8'h12};

    rst_n  = 1'b0;
    ce     = 1'b1;
    dvalid = 1'b0;
    lanes  = '0;
    for (int i = 0; i < NC; i++) dsel[i] = '0;
    flush_model();
    repeat (2) tick();
    for (int i = 0; i < NC; i++)
      if (CL[i] > 0) chk("reset_state", i, observe(i), '0);
    rst_n = 1'b1;

    // Sweep on dut0 (8 lanes, latency 3) and in/out-of-range selects on dut1 (5 lanes, latency 2).
    set_ramp();
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        dsel[0] = tbl[k].sel0;
        dsel[1] = tbl[k].sel1;
        dvalid  = 1'b1;
      end else begin
        dvalid = 1'b0;
      end
      tick();
      if (k >= 2 && k < 10) begin
        z = '{1'b1, tbl[k-2].sel0, tbl[k-2].exp0};
        chk("basic_path", 0, observe(0), z);
      end
      if (k >= 1 && k < 9) begin
        z = '{1'b1, tbl[k-1].sel1, tbl[k-1].exp1};
        chk("out_of_range", 1, observe(1), z);
      end
    end

    // Stall on dut2 (latency 4): A, B, C then ce low for 3 cycles.
    dvalid = 1'b0;
    repeat (6) tick();
    got_q.delete();
    for (int k = 0; k < 14; k++) begin
      ce = !(k >= 3 && k < 6);
      if (k < 3) begin
        dsel[2] = (k == 0) ? 6'd3 : (k == 1) ? 6'd6 : 6'd1;
        dvalid  = 1'b1;
      end else begin
        dvalid = 1'b0;
      end
      tick();
      if (ce && o_v[2]) got_q.push_back(observe(2));
    end
    ce = 1'b1;
    chk_int("stall_count", got_q.size(), 3);
    if (got_q.size() >= 3) begin
      z = '{1'b1, 6'd3, 8'h13};
      chk("stall_a", 2, got_q[0], z);
      z = '{1'b1, 6'd6, 8'h16};
      chk("stall_b", 2, got_q[1], z);
      z = '{1'b1, 6'd1, 8'h11};
      chk("stall_c", 2, got_q[2], z);
    end

    // Exact arrival cycle for latency 5 (tree plus padding) and latency 6.
    dvalid = 1'b0;
    repeat (7) tick();
    for (int k = 0; k < 8; k++) begin
      dvalid  = (k == 0);
      dsel[3] = 6'd2;
      dsel[5] = 6'd9;
      tick();
      chk_int("latency5_valid", int'(o_v[3]), (k == 4) ? 1 : 0);
      chk_int("latency6_valid", int'(o_v[5]), (k == 5) ? 1 : 0);
    end

    // Asynchronous reset with samples in flight.
    for (int k = 0; k < 3; k++) begin
      drive_random();
      dvalid = 1'b1;
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NC; i++)
      if (CL[i] > 0) chk("reset_midflight", i, observe(i), '0);
    flush_model();
    tick();
    rst_n  = 1'b1;
    dvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_int("no_stale_valid", int'(o_v[0]) + int'(o_v[5]) + int'(o_v[6]), 0);
    end

    // Random regression with random enables, valids and selects.
    for (int k = 0; k < 400; k++) begin
      drive_random();
      ce = ($urandom_range(0, 3) != 0);
      tick();
    end
    ce = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_pipeline.md
# mux_pipeline

Pipelined N:1 multiplexer with a fixed, parameterised output latency; the gathering counterpart of the `dmux_pipeline` demultiplexer. It collapses `INPUT_COUNT` lanes into one through a tree of power-of-two-radix mux units, registering between tree levels. A valid tag and the selected index travel alongside the data, so downstream logic knows when each result lands and which lane it came from. A global clock-enable stalls the whole pipeline.

## Interface
- `WIDTH`, 1, bits per lane.
- `INPUT_COUNT`, 2, number of input lanes; must be at least 2.
- `LATENCY`, 0, cycles from input sample to output. 0 gives a purely combinational path.
- `PRINT`, 0, nonzero makes elaboration print the derived structure parameters.
- Derived: `SELECT_SIZE = $clog2(INPUT_COUNT)`.
- Derived: `SEL_WIDTH = ceil(SELECT_SIZE / LATENCY)`, or `SELECT_SIZE` when `LATENCY` is 0.
- Derived: `MUX_SIZE = 1 << SEL_WIDTH`.
- Derived: `STRUCTURE_DEPTH = ceil(SELECT_SIZE / SEL_WIDTH)`.

Ports:
- `clk` input 1: the single clock. Rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ce` input 1: clock enable. When low, every register holds its value.
- `sel` input `SELECT_SIZE`: lane index, sampled together with `in`.
- `in` input `WIDTH*INPUT_COUNT`: lane k occupies `in[k*WIDTH +: WIDTH]`.
- `in_valid` input 1: qualifies `sel` and `in`.
- `out` output `WIDTH`: the selected lane.
- `out_valid` output 1: `in_valid` delayed by `LATENCY`.
- `out_sel` output `SELECT_SIZE`: `sel` delayed by `LATENCY`.

## Operation
- **Level 0** muxes groups of `MUX_SIZE` adjacent lanes using `sel[SEL_WIDTH-1:0]`.
  - Level i uses `sel[i*SEL_WIDTH +: SEL_WIDTH]` on the outputs of level i-1.
  - The last level may be narrower than `MUX_SIZE`.
  - Group members beyond `INPUT_COUNT` read as zero.
- **Register placement:**
  - There is a register rank after each of the first `min(LATENCY, STRUCTURE_DEPTH)` levels.
  - If `LATENCY > STRUCTURE_DEPTH`, plain delay registers are appended after the tree so total latency is exactly `LATENCY`.
- **Select pipeline:** unconsumed `sel` bits are registered alongside each data rank. Level i always sees the `sel` bits belonging to its own data.
- **Tag pipeline:** the full `sel` and `in_valid` are also carried through `LATENCY` registers to `out_sel` and `out_valid`.
- **Data path:** data registers load on every enabled edge regardless of `in_valid`. `in_valid` only tags the data.
- **Out-of-range select:** `sel >= INPUT_COUNT` produces `out = 0`. `out_sel` and `out_valid` still propagate normally.
- **Stall:** while `ce = 0`, all ranks, including the tag pipeline, hold. When `ce` returns high, flow resumes with no loss or duplication.
- **`LATENCY = 0`:**
  - `out` is combinational from `in`/`sel`.
  - `out_valid = in_valid` and `out_sel = sel`.
  - `ce` and `rst_n` have no effect on the outputs.
- **Reset:**
  - All data, select, tag and valid registers clear to 0 immediately while `rst_n = 0`.
  - The outputs read `out = 0`, `out_valid = 0`, `out_sel = 0`.
  - A reset in mid-flight discards every in-flight sample.
- **Elaboration (`PRINT != 0`):** displays `SELECT_SIZE`, `SEL_WIDTH`, `MUX_SIZE`, `STRUCTURE_DEPTH` and the padding count.

## Timing
- **Latency:** a sample presented at enabled edge t appears on `out`/`out_valid`/`out_sel` after edge t+`LATENCY-1`, i.e. it is visible during cycle t+`LATENCY`. Latency counts enabled edges only.
- **Throughput:** one sample per enabled cycle; there is no back-pressure other than `ce`.
- **Critical path:** each register rank covers at most one `MUX_SIZE`:1 mux level.
  - Example: `INPUT_COUNT = 16`, `LATENCY = 2` gives `SEL_WIDTH = 2`, two 4:1 levels, two ranks.
  - Example: `INPUT_COUNT = 16`, `LATENCY = 6` gives four 2:1 levels plus 2 padding ranks.
- **Reset release:** asynchronous assertion; the first capture is on the first enabled edge after `rst_n` rises. `out_valid` stays 0 for at least `LATENCY` enabled edges after release.
- **`ce` and `rst_n` together:** reset wins.

## Test plan
- **Basic path:** `INPUT_COUNT = 8`, `WIDTH = 8`, `LATENCY = 3`, lane k = `0x10+k`. Sweep `sel` 0..7 back-to-back with `in_valid = 1` → `out` = `0x10`..`0x17` on consecutive cycles starting 3 cycles later, with `out_sel` matching and `out_valid = 1` throughout.
- **Out-of-range select:** `INPUT_COUNT = 5`, `LATENCY = 2`, `sel = 6` → `out = 0` after 2 cycles, with `out_sel = 6` and `out_valid = 1`.
- **Stall:** `LATENCY = 4`. Send samples A, B, C, then hold `ce = 0` for 3 cycles → outputs freeze; after `ce` returns high, A, B, C emerge in order, each exactly once.
- **Reset mid-flight:** 3 samples in flight, pulse `rst_n` low asynchronously mid-cycle → `out`, `out_valid`, `out_sel` go to 0 immediately, and no stale sample appears after release.
- **Zero latency and padding:**
  - `LATENCY = 0`: random `sel`/`in` → `out` equals the selected lane in the same cycle.
  - `INPUT_COUNT = 4`, `LATENCY = 5`: → exactly 5-cycle latency.
- **Random regression:** random `INPUT_COUNT` in 2..33, random `LATENCY` in 0..6, random `ce`/`in_valid` → scoreboard holds `out == in_then[sel_then]` whenever `out_valid` is high.
